// File: rtl/rxgetmachdr.sv
// Single-register AXI-network packet pass-through that captures the 14-byte
// Ethernet header (dst MAC, src MAC, EtherType) and hands it to the routing table.
module rxgetmachdr #(
    parameter int DW                = 64,
    parameter int WBITS             = $clog2(DW/8),
    parameter bit OPT_LITTLE_ENDIAN = 1'b0,
    parameter bit OPT_LOWPOWER      = 1'b0,
    parameter int CNTW              = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [DW-1:0]    S_DATA,
    input  logic [WBITS-1:0] S_BYTES,
    input  logic             S_ABORT,
    input  logic             S_LAST,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [DW-1:0]    M_DATA,
    output logic [WBITS-1:0] M_BYTES,
    output logic             M_ABORT,
    output logic             M_LAST,
    output logic             TBL_VALID,
    input  logic             TBL_READY,
    output logic [47:0]      TBL_DSTMAC,
    output logic [47:0]      TBL_SRCMAC,
    output logic [15:0]      TBL_ETHTYPE,
    output logic [CNTW-1:0]  o_runts
);

    localparam int         NB         = DW / 8;
    localparam logic [7:0] BEAT_BYTES = 8'(NB);
    localparam logic [7:0] HDR_BYTES  = 8'd14;

    logic         accept, abort_acc, last_acc, hdr_done, m_active;
    logic [7:0]   posn, nbytes, span;
    logic [111:0] staging, hdr_next;

    function automatic logic [7:0] lane(input logic [DW-1:0] data, input logic [7:0] idx);
        lane = '0;
        for (int j = 0; j < NB; j++)
            if (8'(j) == idx)
                lane = OPT_LITTLE_ENDIAN ? data[8*j +: 8] : data[DW-8-8*j +: 8];
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
        sat_inc = (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    // Stall on a pending header record so no table entry is ever overwritten
    assign S_READY   = !i_reset && (!TBL_VALID || TBL_READY) && (!M_VALID || M_READY);
    assign accept    = S_VALID && S_READY;
    assign abort_acc = accept && S_ABORT;
    assign last_acc  = accept && S_LAST && !S_ABORT;
    assign nbytes    = (S_LAST && S_BYTES != '0) ? 8'(S_BYTES) : BEAT_BYTES;
    assign span      = posn + nbytes;
    assign hdr_done  = span >= HDR_BYTES;

    always_comb begin
        hdr_next = staging;
        for (int k = 0; k < 14; k++)
            if (8'(k) >= posn && 8'(k) < span)
                hdr_next[111-8*k -: 8] = lane(S_DATA, 8'(k) - posn);
    end

    // Forwarding stage
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            M_VALID <= 1'b0;
            M_DATA  <= '0;
            M_BYTES <= '0;
            M_LAST  <= 1'b0;
            M_ABORT <= 1'b0;
        end else begin
            if (accept && !S_ABORT) begin
                M_VALID <= 1'b1;
                M_DATA  <= S_DATA;
                M_BYTES <= S_BYTES;
                M_LAST  <= S_LAST;
            end else if (!M_VALID || M_READY) begin
                M_VALID <= 1'b0;
                if (OPT_LOWPOWER) begin
                    M_DATA  <= '0;
                    M_BYTES <= '0;
                    M_LAST  <= 1'b0;
                end
            end
            if (abort_acc && m_active)
                M_ABORT <= 1'b1;
            else if (!M_VALID || M_READY)
                M_ABORT <= 1'b0;
        end
    end

    // Packet position tracking and header staging
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_active <= 1'b0;
            posn     <= '0;
            staging  <= '0;
        end else if (accept) begin
            if (S_ABORT || S_LAST) begin
                m_active <= 1'b0;
                posn     <= '0;
            end else begin
                m_active <= 1'b1;
                if (posn < HDR_BYTES)
                    posn <= span;
            end
            if (!S_ABORT)
                staging <= hdr_next;
        end
    end

    // Table record and runt counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            TBL_VALID   <= 1'b0;
            TBL_DSTMAC  <= '0;
            TBL_SRCMAC  <= '0;
            TBL_ETHTYPE <= '0;
            o_runts     <= '0;
        end else begin
            if (last_acc && hdr_done) begin
                TBL_VALID   <= 1'b1;
                TBL_DSTMAC  <= hdr_next[111:64];
                TBL_SRCMAC  <= hdr_next[63:16];
                TBL_ETHTYPE <= hdr_next[15:0];
            end else if (TBL_READY) begin
                TBL_VALID <= 1'b0;
                if (OPT_LOWPOWER) begin
                    TBL_DSTMAC  <= '0;
                    TBL_SRCMAC  <= '0;
                    TBL_ETHTYPE <= '0;
                end
            end
            if (last_acc && !hdr_done)
                o_runts <= sat_inc(o_runts);
        end
    end

endmodule

// File: tb/tb_rxgetmachdr.sv
// Bench for rxgetmachdr: byte-queue packet model compared every cycle (DW=64 BE),
// plus directed literal checks and a DW=32 little-endian low-power instance.
module tb_rxgetmachdr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_ready, s_abort = 1'b0, s_last = 1'b0;
    logic [63:0] s_data = '0;
    logic [2:0]  s_bytes = '0;
    logic        m_valid, m_ready = 1'b1, m_abort, m_last;
    logic [63:0] m_data;
    logic [2:0]  m_bytes;
    logic        tbl_valid, tbl_ready = 1'b1;
    logic [47:0] tbl_dst, tbl_src;
    logic [15:0] tbl_type, runts;

    logic        c_s_valid = 1'b0, c_s_ready, c_s_last = 1'b0;
    logic [31:0] c_s_data = '0, c_m_data;
    logic [1:0]  c_s_bytes = '0, c_m_bytes;
    logic        c_m_valid, c_m_abort, c_m_last, c_tbl_valid;
    logic [47:0] c_tbl_dst, c_tbl_src;
    logic [15:0] c_tbl_type, c_runts;

    int   n_checks = 0, n_fail = 0;
    bit   cmp_en = 0, rnd_mode = 0, hold_tbl = 0;
    logic [7:0] pbytes [0:127];

    always #5 clk = ~clk;

    rxgetmachdr #(.DW(64)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data), .S_BYTES(s_bytes),
        .S_ABORT(s_abort), .S_LAST(s_last),
        .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data), .M_BYTES(m_bytes),
        .M_ABORT(m_abort), .M_LAST(m_last),
        .TBL_VALID(tbl_valid), .TBL_READY(tbl_ready), .TBL_DSTMAC(tbl_dst),
        .TBL_SRCMAC(tbl_src), .TBL_ETHTYPE(tbl_type), .o_runts(runts)
    );

    rxgetmachdr #(.DW(32), .OPT_LITTLE_ENDIAN(1'b1), .OPT_LOWPOWER(1'b1)) u_dut32 (
        .i_clk(clk), .i_reset(rst),
        .S_VALID(c_s_valid), .S_READY(c_s_ready), .S_DATA(c_s_data), .S_BYTES(c_s_bytes),
        .S_ABORT(1'b0), .S_LAST(c_s_last),
        .M_VALID(c_m_valid), .M_READY(1'b1), .M_DATA(c_m_data), .M_BYTES(c_m_bytes),
        .M_ABORT(c_m_abort), .M_LAST(c_m_last),
        .TBL_VALID(c_tbl_valid), .TBL_READY(1'b1), .TBL_DSTMAC(c_tbl_dst),
        .TBL_SRCMAC(c_tbl_src), .TBL_ETHTYPE(c_tbl_type), .o_runts(c_runts)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    logic        e_mv = 0, e_ml = 0, e_ma = 0, e_tv = 0, e_act = 0;
    logic [63:0] e_md = '0;
    logic [2:0]  e_mb = '0;
    logic [47:0] e_dst = '0, e_src = '0;
    logic [15:0] e_type = '0, e_runts = '0;
    logic [7:0]  pkt [$];
    bit          macc, old_mv, mload;
    int          nb_m;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            e_mv = 0; e_ml = 0; e_ma = 0; e_tv = 0; e_act = 0; e_md = '0; e_mb = '0;
            e_dst = '0; e_src = '0; e_type = '0; e_runts = '0;
            pkt.delete();
        end else begin
            macc   = s_valid && (!e_tv || tbl_ready) && (!e_mv || m_ready);
            old_mv = e_mv;
            mload  = 0;
            if (macc && !s_abort) begin
                e_mv = 1; e_md = s_data; e_mb = s_bytes; e_ml = s_last;
            end else if (!old_mv || m_ready) begin
                e_mv = 0;
            end
            if (macc && s_abort && e_act) e_ma = 1;
            else if (!old_mv || m_ready) e_ma = 0;
            if (macc && s_abort) begin
                pkt.delete();
                e_act = 0;
            end else if (macc) begin
                nb_m = (s_last && s_bytes != 0) ? int'(s_bytes) : 8;
                for (int i = 0; i < nb_m; i++) pkt.push_back(s_data[63-8*i -: 8]);
                if (s_last) begin
                    if (pkt.size() >= 14) begin
                        mload = 1;
                        for (int k = 0; k < 6; k++) e_dst = {e_dst[39:0], pkt[k]};
                        for (int k = 6; k < 12; k++) e_src = {e_src[39:0], pkt[k]};
                        e_type = {pkt[12], pkt[13]};
                    end else if (e_runts != 16'hffff) begin
                        e_runts++;
                    end
                    pkt.delete();
                    e_act = 0;
                end else begin
                    e_act = 1;
                end
            end
            if (mload) e_tv = 1;
            else if (tbl_ready) e_tv = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("s_ready", s_ready, !rst && (!e_tv || tbl_ready) && (!e_mv || m_ready));
            chk("m_valid", m_valid, e_mv);
            chk("m_abort", m_abort, e_ma);
            chk("tbl_valid", tbl_valid, e_tv);
            chk("runts", runts, e_runts);
            if (e_mv) begin
                chk("m_data", m_data, e_md);
                chk("m_bytes", m_bytes, e_mb);
                chk("m_last", m_last, e_ml);
            end
            if (e_tv) begin
                chk("tbl_dst", tbl_dst, e_dst);
                chk("tbl_src", tbl_src, e_src);
                chk("tbl_type", tbl_type, e_type);
            end
        end
    end

    // Output-side ready generation
    initial forever begin
        @(posedge clk);
        #2;
        m_ready   = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        tbl_ready = hold_tbl ? 1'b0 : (rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] beat_of(input int bi, input int len);
        logic [63:0] d;
        d = {$urandom, $urandom};
        for (int i = 0; i < 8; i++)
            if (bi*8 + i < len) d[63-8*i -: 8] = pbytes[bi*8 + i];
        return d;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [2:0] b, input logic l, input logic a);
        bit ok = 0;
        s_valid = 1; s_data = d; s_bytes = b; s_last = l; s_abort = a;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready;
            sync();
        end
        chk("accept_timeout", ok, 1'b1);
        s_valid = 0; s_last = 0; s_abort = 0;
    endtask

    task automatic send_pkt(input int len, input int abort_beat, input bit gaps);
        int nb = (len + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            logic l = (bi == nb - 1) && (bi != abort_beat);
            logic [2:0] b = l ? 3'(len % 8) : 3'($urandom);
            send_beat(beat_of(bi, len), b, l, bi == abort_beat);
            if (bi == abort_beat) break;
            if (gaps) repeat ($urandom_range(0, 2)) sync();
        end
    endtask

    task automatic load_hdr(input logic [7:0] base);
        for (int i = 0; i < 128; i++) pbytes[i] = 8'($urandom);
        if (base == 8'h00) begin
            pbytes[0] = 8'h01; pbytes[1] = 8'h23; pbytes[2] = 8'h45; pbytes[3] = 8'h67;
            pbytes[4] = 8'h89; pbytes[5] = 8'hAB; pbytes[6] = 8'h02; pbytes[7] = 8'hAA;
            pbytes[8] = 8'hBB; pbytes[9] = 8'hCC; pbytes[10] = 8'hDD; pbytes[11] = 8'hEE;
            pbytes[12] = 8'h08; pbytes[13] = 8'h00;
        end else begin
            for (int i = 0; i < 14; i++) pbytes[i] = base + 8'(i);
        end
    endtask

    task automatic chk_std_record(input string tag);
        chk({tag, "_tv"}, tbl_valid, 1'b1);
        chk({tag, "_dst"}, tbl_dst, 48'h0123456789AB);
        chk({tag, "_src"}, tbl_src, 48'h02AABBCCDDEE);
        chk({tag, "_type"}, tbl_type, 16'h0800);
    endtask

    task automatic c_send(input logic [31:0] d, input logic [1:0] b, input logic l);
        bit ok = 0;
        c_s_valid = 1; c_s_data = d; c_s_bytes = b; c_s_last = l;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = c_s_ready;
            sync();
        end
        chk("c_accept_timeout", ok, 1'b1);
        c_s_valid = 0; c_s_last = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_tbl_valid", tbl_valid, 1'b0);
        chk("rst_runts", runts, 16'd0);
        sync();
        rst = 0;
        cmp_en = 1;

        // 64-byte packet, big endian
        load_hdr(8'h00);
        send_pkt(64, -1, 0);
        @(negedge clk);
        chk_std_record("pkt64");
        sync();

        // Same header on the 32-bit little-endian low-power instance
        c_send(32'h67452301, 2'd0, 1'b0);
        c_send(32'hAA02AB89, 2'd0, 1'b0);
        c_send(32'hEEDDCCBB, 2'd0, 1'b0);
        c_send(32'h11220008, 2'd0, 1'b0);
        c_send(32'h55667788, 2'd0, 1'b1);
        @(negedge clk);
        chk("c_tv", c_tbl_valid, 1'b1);
        chk("c_dst", c_tbl_dst, 48'h0123456789AB);
        chk("c_src", c_tbl_src, 48'h02AABBCCDDEE);
        chk("c_type", c_tbl_type, 16'h0800);
        chk("c_m_data", c_m_data, 32'h55667788);
        chk("c_m_last", c_m_last, 1'b1);
        sync();
        @(negedge clk);
        chk("c_lp_m_valid", c_m_valid, 1'b0);
        chk("c_lp_m_data", c_m_data, 32'h0);
        chk("c_lp_m_last", c_m_last, 1'b0);
        chk("c_lp_tbl_dst", c_tbl_dst, 48'h0);
        chk("c_runts", c_runts, 16'd0);
        sync();

        // 12-byte runt
        send_pkt(12, -1, 0);
        @(negedge clk);
        chk("runt_tv", tbl_valid, 1'b0);
        chk("runt_cnt", runts, 16'd1);
        chk("runt_m_last", m_last, 1'b1);
        chk("runt_m_bytes", m_bytes, 3'd4);
        sync();

        // Abort on beat 3, then a clean packet
        send_pkt(64, 3, 0);
        @(negedge clk);
        chk("abort_m_abort", m_abort, 1'b1);
        chk("abort_m_valid", m_valid, 1'b0);
        chk("abort_tv", tbl_valid, 1'b0);
        chk("abort_runts", runts, 16'd1);
        sync();
        send_pkt(64, -1, 0);
        @(negedge clk);
        chk_std_record("post_abort");
        sync();

        // Table backpressure with a second packet waiting
        hold_tbl = 1;
        sync();
        send_pkt(20, -1, 0);
        load_hdr(8'h10);
        fork
            send_pkt(24, -1, 0);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_s_ready", s_ready, 1'b0);
                    chk_std_record("bp_hold");
                end
                hold_tbl = 0;
            end
        join
        @(negedge clk);
        chk("bp2_tv", tbl_valid, 1'b1);
        chk("bp2_dst", tbl_dst, 48'h101112131415);
        chk("bp2_type", tbl_type, 16'h1C1D);
        sync();

        // Asynchronous reset on beat 2
        load_hdr(8'h00);
        send_beat(beat_of(0, 64), 3'd0, 1'b0, 1'b0);
        send_beat(beat_of(1, 64), 3'd0, 1'b0, 1'b0);
        s_valid = 1; s_data = beat_of(2, 64);
        #2;
        rst = 1;
        #1;
        chk("arst_s_ready", s_ready, 1'b0);
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_m_data", m_data, 64'h0);
        chk("arst_m_abort", m_abort, 1'b0);
        chk("arst_tbl_valid", tbl_valid, 1'b0);
        chk("arst_tbl_dst", tbl_dst, 48'h0);
        chk("arst_runts", runts, 16'd0);
        s_valid = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        send_pkt(64, -1, 0);
        @(negedge clk);
        chk_std_record("post_rst");
        sync();

        // Randomized traffic
        rnd_mode = 1;
        for (int p = 0; p < 150; p++) begin
            int len = $urandom_range(1, 100);
            int ab  = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, (len + 7) / 8 - 1)) : -1;
            load_hdr(8'($urandom_range(1, 255)));
            send_pkt(len, ab, 1);
        end
        rnd_mode = 0;
        repeat (6) sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rxgetmachdr.md
Name: rxgetmachdr

Overview:
- Successor to the single-field source-MAC extractor in the 10Gb switch RX path.
- Sits between the per-port RX pipeline and the routing table.
- Forwards the packet unchanged, one register stage, AXI-network style (VALID/READY/DATA/BYTES/LAST/ABORT).
- Captures the full 14-byte Ethernet header (destination MAC, source MAC, EtherType) for any beat width. Reports the header to the table only after a complete, non-aborted packet. Counts runt packets.

Parameters:
- DW, 64, beat width in bits; multiple of 8, 32..512.
- WBITS, $clog2(DW/8), width of the BYTES field.
- OPT_LITTLE_ENDIAN, 0: 1 means byte k of a beat is at bits [8k+7:8k]; 0 means byte 0 is at bits [DW-1:DW-8].
- OPT_LOWPOWER, 0: 1 means data outputs are zeroed whenever their VALID is low.
- CNTW, 16, width of the runt counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; asynchronous, active-high
- S_VALID  in  1  input beat valid
- S_READY  out  1  input ready
- S_DATA  in  DW  input beat data
- S_BYTES  in  WBITS  valid bytes in the last beat; 0 means DW/8
- S_ABORT  in  1  abort the current packet
- S_LAST  in  1  last beat of the packet
- M_VALID  out  1  output beat valid
- M_READY  in  1  output ready
- M_DATA  out  DW  output beat data
- M_BYTES  out  WBITS  output byte count
- M_ABORT  out  1  output abort
- M_LAST  out  1  output last beat
- TBL_VALID  out  1  header record valid
- TBL_READY  in  1  table accepts the record
- TBL_DSTMAC  out  48  header bytes 0..5 (byte 0 is the MSB)
- TBL_SRCMAC  out  48  header bytes 6..11
- TBL_ETHTYPE  out  16  header bytes 12..13
- o_runts  out  CNTW  saturating count of runt packets

Behaviour:
- Reset: asynchronous, active-high; all outputs, counters and header state go to 0.
- Ready: S_READY = (!TBL_VALID || TBL_READY) && (!M_VALID || M_READY). S_READY is low during reset.
- Forwarding path:
  - On accept, M_DATA/M_BYTES/M_LAST load from S_* and M_VALID rises the next cycle (1-cycle latency).
  - When (!M_VALID || M_READY) with no accept, M_VALID clears.
  - A beat with S_ABORT asserted is never forwarded as data.
- Packet tracking:
  - `m_active` is set by an accepted non-last beat and cleared by LAST or abort.
  - S_ABORT while `m_active`: M_ABORT is set and held until (!M_VALID || M_READY).
  - An abort while idle is ignored and emits nothing.
  - Byte position `posn` starts at 0 and advances by DW/8 per accepted non-last beat. It saturates once ≥14, and clears on LAST or abort.
- Header capture:
  - Header byte k (k<14) is taken from the lane k−posn of an accepted beat when posn ≤ k < posn+nbytes.
  - nbytes is DW/8, or S_BYTES (0 treated as DW/8) on the last beat.
  - Header bytes land in a 112-bit staging register.
  - With DW=32 this spans 4 beats; with DW≥128 it is a single beat.
- Table record:
  - On the accepted LAST beat with S_ABORT low and posn+nbytes ≥ 14, staging is copied to TBL_* and TBL_VALID=1 the next cycle.
  - TBL_VALID is held, and TBL_* are stable, until TBL_READY.
  - TBL_READY in the same cycle as a new LAST: the new record replaces the old one, with no gap.
- Runt: a non-aborted LAST with posn+nbytes < 14 emits no record. o_runts increments and saturates at all-ones. The packet itself is still forwarded.
- Aborted packets: staging is discarded and no record is emitted.
- A packet shorter than 14 bytes that is aborted is not a runt.
- Backpressure: while TBL_VALID && !TBL_READY, input stalls even if M is free. This guarantees no header is lost.
- OPT_LOWPOWER: M_DATA, M_BYTES and M_LAST are 0 when M_VALID=0. TBL_* are 0 when TBL_VALID=0.

Test Plan:
- **DW=64, big endian, 64-byte packet.** Beat0=0x0123456789AB02AA, beat1=0xBBCCDDEE0800xxxx, LAST with BYTES=0 on beat 7 → TBL_VALID the cycle after beat 7 with DST=0x0123456789AB, SRC=0x02AABBCCDDEE, TYPE=0x0800. M output is identical with 1-cycle latency.
- **DW=32, same header across 4 beats, then LAST** → same TBL values. Repeat with OPT_LITTLE_ENDIAN=1 and byte-reversed lanes → same values.
- **12-byte packet, DW=64 (beat1 BYTES=4, LAST)** → no TBL_VALID, o_runts=1. Forwarded with M_LAST and M_BYTES=4.
- **Abort on beat 3 of a 64-byte packet** → M_ABORT=1 until accepted, no TBL_VALID, o_runts unchanged. The next clean packet produces a correct record.
- **TBL_READY held low for 10 cycles after a record** → S_READY=0 throughout and TBL_* stable. A back-to-back second packet's record appears only after TBL_READY.
- **Assert i_reset asynchronously mid-packet (beat 2)** → all outputs 0 immediately. The next packet is captured from byte 0 correctly.
